// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM encoding, glyphs, prescaler sizing.
// Glyphs are active-high in abcdefg order (bit 6 = a, bit 0 = g).
package seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] GLYPH_0    = 7'h7E;
    localparam logic [6:0] GLYPH_1    = 7'h30;
    localparam logic [6:0] GLYPH_2    = 7'h6D;
    localparam logic [6:0] GLYPH_3    = 7'h79;
    localparam logic [6:0] GLYPH_4    = 7'h33;
    localparam logic [6:0] GLYPH_5    = 7'h5B;
    localparam logic [6:0] GLYPH_6    = 7'h5F;
    localparam logic [6:0] GLYPH_7    = 7'h70;
    localparam logic [6:0] GLYPH_8    = 7'h7F;
    localparam logic [6:0] GLYPH_9    = 7'h7B;
    localparam logic [6:0] GLYPH_DASH = 7'h01;

    // Wide enough to count 0..max-1 of either phase; never narrower than one bit.
    function automatic int pre_width(input int show_cyc, input int blank_cyc);
        int m;
        m = (show_cyc > blank_cyc) ? show_cyc : blank_cyc;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_digit_seg_lut.sv
// Digit-to-glyph lookup: 4-bit value plus blank flag -> active-high abcdefg segments.
// Latency: combinational. Backpressure: none.
// Values 0xA-0xF render as a dash; blank forces all segments off.
module digit_seg_lut
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] dig,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = '0;
        if (!blank) begin
            case (dig)
                4'd0:    seg = GLYPH_0;
                4'd1:    seg = GLYPH_1;
                4'd2:    seg = GLYPH_2;
                4'd3:    seg = GLYPH_3;
                4'd4:    seg = GLYPH_4;
                4'd5:    seg = GLYPH_5;
                4'd6:    seg = GLYPH_6;
                4'd7:    seg = GLYPH_7;
                4'd8:    seg = GLYPH_8;
                4'd9:    seg = GLYPH_9;
                default: seg = GLYPH_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with inter-digit blanking and per-frame BCD snapshot.
// Latency: first anode BLANK_CYC+1 cycles after en rises; all outputs registered alongside the FSM state.
// Backpressure: none; en=0 darkens the display on the next edge and restarts the scan at digit 0.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NDIG           = 4,
    parameter int SHOW_CYC       = 50000,
    parameter int BLANK_CYC      = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       blank_lz,
    input  logic [4*NDIG-1:0]          bcd_in,
    input  logic [NDIG-1:0]            dp_in,
    output logic                       segA,
    output logic                       segB,
    output logic                       segC,
    output logic                       segD,
    output logic                       segE,
    output logic                       segF,
    output logic                       segG,
    output logic                       segDP,
    output logic [NDIG-1:0]            an,
    output logic [$clog2(NDIG)-1:0]    digit_idx,
    output logic                       frame_tick
);

    localparam int IW = $clog2(NDIG);
    localparam int PW = pre_width(SHOW_CYC, BLANK_CYC);
    localparam logic AN_POL  = (AN_ACTIVE_LOW != 0);
    localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);
    localparam logic [PW-1:0] SHOW_LAST  = PW'(SHOW_CYC - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

    state_t            state_q, state_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] snap_bcd_q, snap_bcd_d;
    logic [NDIG-1:0]   snap_dp_q, snap_dp_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              tick_q, tick_d;

    logic [NDIG-1:0]   lz_mask;
    logic              all_zero;
    logic              lit_blank;
    logic              lut_blank;
    logic [3:0]        cur_dig;
    logic [6:0]        lut_seg;

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q + PW'(1);
        idx_d      = idx_q;
        snap_bcd_d = snap_bcd_q;
        snap_dp_d  = snap_dp_q;
        tick_d     = 1'b0;
        case (state_q)
            ST_OFF: begin
                pre_d = '0;
                idx_d = '0;
                if (en) state_d = ST_BLANK;
            end
            ST_BLANK: begin
                if (pre_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    pre_d   = '0;
                    // Frame coherence: the whole frame displays this one snapshot.
                    if (idx_q == '0) begin
                        snap_bcd_d = bcd_in;
                        snap_dp_d  = dp_in;
                    end
                end
            end
            ST_SHOW: begin
                if (pre_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    pre_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                    tick_d  = (idx_q == IDX_LAST);
                end
            end
            default: begin
                state_d = ST_OFF;
                pre_d   = '0;
                idx_d   = '0;
            end
        endcase
        if (!en) begin
            state_d = ST_OFF;
            pre_d   = '0;
            idx_d   = '0;
            tick_d  = 1'b0;
        end
    end

    // Outputs are derived from next-state values so they change on the same edge as the state.
    always_comb begin
        all_zero = 1'b1;
        lz_mask  = '0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            all_zero   = all_zero && (snap_bcd_d[4*i +: 4] == 4'd0);
            lz_mask[i] = all_zero;
        end
        cur_dig   = snap_bcd_d[{idx_d, 2'b00} +: 4];
        lit_blank = blank_lz && lz_mask[idx_d];
        lut_blank = (state_d != ST_SHOW) || lit_blank;

        an_d = {NDIG{AN_POL}};
        if (state_d == ST_SHOW) an_d[idx_d] = ~AN_POL;
        seg_d = lut_seg ^ {7{SEG_POL}};
        dp_d  = ((state_d == ST_SHOW) && !lit_blank && snap_dp_d[idx_d]) ^ SEG_POL;
    end

    digit_seg_lut u_lut (
        .dig   (cur_dig),
        .blank (lut_blank),
        .seg   (lut_seg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_OFF;
            pre_q      <= '0;
            idx_q      <= '0;
            snap_bcd_q <= '0;
            snap_dp_q  <= '0;
            an_q       <= {NDIG{AN_POL}};
            seg_q      <= {7{SEG_POL}};
            dp_q       <= SEG_POL;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            snap_bcd_q <= snap_bcd_d;
            snap_dp_q  <= snap_dp_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            tick_q     <= tick_d;
        end
    end

    assign {segA, segB, segC, segD, segE, segF, segG} = seg_q;
    assign segDP      = dp_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display. It shares one segment bus across all digits, driven from a packed BCD vector.
- Rotates the anode enables through the digits.
- Inserts a blanking gap between digits to suppress ghosting.
- Snapshots the BCD input once per frame so each frame is coherent.
- Applies optional leading-zero blanking.
It sits between the BCD counter datapath and the board display pins.

Parameters:
NDIG, 4, number of digits scanned (2..8)
SHOW_CYC, 50000, clk cycles each digit is lit (>=1)
BLANK_CYC, 1000, clk cycles all anodes off between digits (>=1)
SEG_ACTIVE_LOW, 1, 1 = segment/DP pins active-low
AN_ACTIVE_LOW, 1, 1 = anode pins active-low

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
en  in  1  1 = scanning; 0 = display dark
blank_lz  in  1  1 = blank leading zeros
bcd_in  in  4*NDIG  packed digits; [3:0] = digit 0 (rightmost)
dp_in  in  NDIG  decimal point per digit
segA..segG  out  1 each  segment drives
segDP  out  1  decimal point drive
an  out  NDIG  anode enables; bit i = digit i
digit_idx  out  clog2(NDIG)  digit currently selected
frame_tick  out  1  one-cycle pulse at end of each complete frame

Behaviour:
- Reset state (asynchronous, while rst=0):
  - FSM = OFF, idx = 0, prescaler = 0, snapshot = 0.
  - All an inactive; all seg/DP inactive; frame_tick = 0.
- All outputs are registered. Each is loaded on the same edge that the FSM enters the state that defines it, so outputs coincide with the state register.
- Prescaler counts 0..N-1 within a state and is cleared on every state change.
- FSM states:
  - OFF: an, seg and DP inactive; idx = 0. If en=1 -> BLANK.
  - BLANK: an and seg inactive for BLANK_CYC cycles.
    - On the last cycle with idx=0, latch bcd_in and dp_in into the frame snapshot.
    - Then -> SHOW.
  - SHOW: an[idx] active and all other an inactive for SHOW_CYC cycles. Segments decode snapshot digit idx; segDP = snapshot dp[idx].
    - On the last cycle: idx <= (idx==NDIG-1) ? 0 : idx+1, then -> BLANK.
    - frame_tick = 1 for the single cycle following the wrap from NDIG-1 to 0.
- en=0 in any state: next cycle -> OFF, idx = 0, outputs inactive. A later en=1 restarts at BLANK for digit 0 (full BLANK_CYC).
- Timing:
  - Digit period = BLANK_CYC + SHOW_CYC.
  - Frame = NDIG*(BLANK_CYC + SHOW_CYC).
  - First anode asserts BLANK_CYC+1 cycles after en rises.
- Leading-zero blanking (blank_lz=1): digit i (i>=1) is blanked when snapshot digits NDIG-1..i are all 0.
  - A blanked digit keeps its anode asserted and forces seg and DP inactive, which preserves duty cycle.
  - Digit 0 is never blanked.
- Decode:
  - 0-9: standard 7-segment glyphs.
  - 0xA-0xF: dash (segG only).
  - Polarity is applied after decode according to SEG_ACTIVE_LOW / AN_ACTIVE_LOW.
- bcd_in changes mid-frame are ignored until the next frame snapshot.
- Asynchronous reset mid-operation forces the reset state immediately.

Decomposition:
- Shared package:
  - FSM state encoding (OFF/BLANK/SHOW).
  - 7-bit glyph constants for 0-9 and dash, in active-high abcdefg order.
  - Prescaler width function (clog2 of max(SHOW_CYC, BLANK_CYC)).
- One combinational sub-module, digit_seg_lut: 4-bit digit plus blank flag -> 7 active-high segment bits.

Test Plan:
Bench parameters: NDIG=4, SHOW_CYC=4, BLANK_CYC=2, both polarities active-low.
1. rst=0 with en=1 -> an=1111, segA..G=1, segDP=1, digit_idx=0, frame_tick=0; after release, first anode active at cycle 3.
2. en=1, bcd_in=16'h1234, dp_in=0, blank_lz=0 ->
   - an sequence 1110('4'), 1101('3'), 1011('2'), 0111('1'), each 4 cycles, separated by 2 cycles of 1111.
   - '4' gives segA..G=1001100.
   - frame_tick pulses every 24 cycles.
3. bcd_in=16'h0007, blank_lz=1 ->
   - digits 3..1: anode asserted, segs all 1; digit 0 shows '7' (0001111).
   - bcd_in=16'h0000 -> digit 0 shows '0' (0000001).
   - blank_lz=0 -> all show '0'.
4. Change bcd_in from 16'h1234 to 16'h5678 while digit 1 is lit -> digits 2,3 still show '2','1'; the next frame shows 8,7,6,5.
5. bcd_in digit0=4'hB, dp_in=4'b0001 -> digit 0 segA..G=1111110 (dash), segDP=0.
6. Deassert en during SHOW of digit 2 -> next cycle an=1111, digit_idx=0; re-assert -> 2 blank cycles, then an=1110.
7. Assert rst mid-SHOW -> outputs go inactive without waiting for a clk edge.
